// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared types and helpers for the instruction fetch unit:
//                fetch state encoding, opcode field position and the
//                predicate that tells whether an opcode carries an immediate.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int OPCODE_MSB = 15;
    localparam int OPCODE_LSB = 11;
    localparam int OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;

    typedef enum logic [1:0] {
        ST_FETCH     = 2'd0,
        ST_FETCH_IMM = 2'd1,
        ST_INT_VEC   = 2'd2
    } fetch_state_t;

    // An instruction is two words long when the top two opcode bits are set.
    function automatic logic is_two_word(input logic [OPCODE_W-1:0] opcode);
        return (opcode[OPCODE_W-1 -: 2] == 2'b11);
    endfunction

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction fetch initiator. Sequences a word-addressed PC,
//                reads instruction memory every non-stalled cycle, assembles
//                one- or two-word instructions and presents them to decode.
//                Handles branch redirects, stalls and interrupt vector fetch.
//  Ports       : clk, rst           - clock, synchronous active-high reset
//                stall              - freeze all state, drop read strobe
//                branch_taken/target- redirect PC
//                irq                - interrupt request pulse
//                mem_*              - instruction memory read port
//                instr_out, imm_out, pc_out, valid_out - decode interface
//                ret_pc_out         - PC saved at interrupt entry
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = 32'd32,
    parameter logic [31:0] INT_VECTOR_ADDR = 32'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        irq,
    input  logic [15:0] mem_read_data,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic        mem_cs,
    output logic [15:0] instr_out,
    output logic [15:0] imm_out,
    output logic [31:0] pc_out,
    output logic        valid_out,
    output logic [31:0] ret_pc_out
);

    fetch_state_t r_state, w_state;
    logic [31:0]  r_pc, w_pc;
    logic [15:0]  r_hold_instr, w_hold_instr;
    logic [31:0]  r_hold_pc, w_hold_pc;
    logic         r_irq_pending, w_irq_pending;

    logic [15:0]  r_instr, w_instr;
    logic [15:0]  r_imm, w_imm;
    logic [31:0]  r_pc_out, w_pc_out;
    logic         r_valid, w_valid;
    logic [31:0]  r_ret_pc, w_ret_pc;

    logic         w_two_word;

    assign w_two_word  = is_two_word(mem_read_data[OPCODE_MSB:OPCODE_LSB]);

    assign mem_address = (r_state == ST_INT_VEC) ? INT_VECTOR_ADDR : r_pc;
    assign mem_read    = ~rst & ~stall;
    assign mem_cs      = mem_read;
    assign mem_write   = 1'b0;

    // ------------------------------------------------------------------
    // Next-state / next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state       = r_state;
        w_pc          = r_pc;
        w_hold_instr  = r_hold_instr;
        w_hold_pc     = r_hold_pc;
        w_irq_pending = r_irq_pending;
        w_instr       = r_instr;
        w_imm         = r_imm;
        w_pc_out      = r_pc_out;
        w_valid       = r_valid;
        w_ret_pc      = r_ret_pc;

        if (branch_taken) begin
            // Redirect wins over everything but reset; a half-built
            // two-word instruction is simply abandoned.
            w_pc    = branch_target;
            w_state = ST_FETCH;
            w_valid = 1'b0;
            if (irq) w_irq_pending = 1'b1;
        end else if (stall) begin
            if (irq) w_irq_pending = 1'b1;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (irq || r_irq_pending) begin
                        // The word at PC is not consumed; it is the
                        // return point once the handler finishes.
                        w_ret_pc      = r_pc;
                        w_valid       = 1'b0;
                        w_state       = ST_INT_VEC;
                        w_irq_pending = 1'b0;
                    end else if (w_two_word) begin
                        w_hold_instr = mem_read_data;
                        w_hold_pc    = r_pc;
                        w_valid      = 1'b0;
                        w_pc         = r_pc + 32'd1;
                        w_state      = ST_FETCH_IMM;
                    end else begin
                        w_instr  = mem_read_data;
                        w_imm    = 16'h0000;
                        w_pc_out = r_pc;
                        w_valid  = 1'b1;
                        w_pc     = r_pc + 32'd1;
                    end
                end
                ST_FETCH_IMM: begin
                    // Interrupts wait until the instruction is whole.
                    if (irq) w_irq_pending = 1'b1;
                    w_instr  = r_hold_instr;
                    w_imm    = mem_read_data;
                    w_pc_out = r_hold_pc;
                    w_valid  = 1'b1;
                    w_pc     = r_pc + 32'd1;
                    w_state  = ST_FETCH;
                end
                ST_INT_VEC: begin
                    if (irq) w_irq_pending = 1'b1;
                    w_pc    = {16'h0000, mem_read_data};
                    w_valid = 1'b0;
                    w_state = ST_FETCH;
                end
                default: begin
                    w_state = ST_FETCH;
                    w_valid = 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // PC / sequencing registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_FETCH;
            r_pc          <= RESET_PC;
            r_hold_instr  <= 16'h0000;
            r_hold_pc     <= 32'h0000_0000;
            r_irq_pending <= 1'b0;
        end else begin
            r_state       <= w_state;
            r_pc          <= w_pc;
            r_hold_instr  <= w_hold_instr;
            r_hold_pc     <= w_hold_pc;
            r_irq_pending <= w_irq_pending;
        end
    end

    // ------------------------------------------------------------------
    // Decode-facing output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_instr  <= 16'h0000;
            r_imm    <= 16'h0000;
            r_pc_out <= 32'h0000_0000;
            r_valid  <= 1'b0;
            r_ret_pc <= 32'h0000_0000;
        end else begin
            r_instr  <= w_instr;
            r_imm    <= w_imm;
            r_pc_out <= w_pc_out;
            r_valid  <= w_valid;
            r_ret_pc <= w_ret_pc;
        end
    end

    assign instr_out  = r_instr;
    assign imm_out    = r_imm;
    assign pc_out     = r_pc_out;
    assign valid_out  = r_valid;
    assign ret_pc_out = r_ret_pc;

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Self-checking bench for fetch_unit: directed scenarios plus
//                a randomized run against a cycle-level behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    localparam logic [31:0] C_RESET_PC = 32'd32;
    localparam logic [31:0] C_VEC_ADDR = 32'd0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        irq = 1'b0;
    logic [15:0] mem_read_data;
    logic [31:0] mem_address;
    logic        mem_read, mem_write, mem_cs;
    logic [15:0] instr_out, imm_out;
    logic [31:0] pc_out, ret_pc_out;
    logic        valid_out;

    logic [15:0] mem [0:4095];
    assign mem_read_data = mem[mem_address[11:0]];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(C_RESET_PC), .INT_VECTOR_ADDR(C_VEC_ADDR)) dut (
        .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
        .branch_target(branch_target), .irq(irq), .mem_read_data(mem_read_data),
        .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
        .mem_cs(mem_cs), .instr_out(instr_out), .imm_out(imm_out),
        .pc_out(pc_out), .valid_out(valid_out), .ret_pc_out(ret_pc_out)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; irq = 1'b0;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic mem_clear();
        for (int a = 0; a < 4096; a++) mem[a] = 16'h0000;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        mem_clear();
        rst = 1'b1;
        tick(); tick();
        n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %h want 0", valid_out); end
        n_checks++; if (instr_out !== 16'h0 || imm_out !== 16'h0) begin n_fail++; $display("FAIL reset_instr got %h/%h want 0/0", instr_out, imm_out); end
        n_checks++; if (pc_out !== 32'h0 || ret_pc_out !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h/%h want 0/0", pc_out, ret_pc_out); end
        n_checks++; if (mem_read !== 1'b0 || mem_cs !== 1'b0 || mem_write !== 1'b0) begin n_fail++; $display("FAIL reset_strobes got rd=%b cs=%b wr=%b want 0", mem_read, mem_cs, mem_write); end
        n_checks++; if (mem_address !== C_RESET_PC) begin n_fail++; $display("FAIL reset_addr got %h want %h", mem_address, C_RESET_PC); end
        rst = 1'b0;
        #1;
        n_checks++; if (mem_read !== 1'b1 || mem_cs !== 1'b1) begin n_fail++; $display("FAIL run_strobes got rd=%b cs=%b want 1", mem_read, mem_cs); end
    endtask

    task automatic test_sequential();
        logic [15:0] words [3];
        words[0] = 16'h1234; words[1] = 16'h4321; words[2] = 16'h8765;
        mem_clear();
        for (int k = 0; k < 3; k++) mem[32+k] = words[k];
        do_reset();
        n_checks++; if (mem_address !== 32'd32) begin n_fail++; $display("FAIL seq_addr0 got %h want 20", mem_address); end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++;
            if (valid_out !== 1'b1 || pc_out !== 32'(32+k) || instr_out !== words[k] ||
                imm_out !== 16'h0 || mem_address !== 32'(33+k)) begin
                n_fail++;
                $display("FAIL seq_%0d got v=%b pc=%h ins=%h imm=%h addr=%h want v=1 pc=%h ins=%h imm=0 addr=%h",
                         k, valid_out, pc_out, instr_out, imm_out, mem_address, 32'(32+k), words[k], 32'(33+k));
            end
        end
    endtask

    task automatic test_two_word();
        mem_clear();
        mem[32] = 16'b11010_000_001_00000;
        mem[33] = 16'h0005;
        do_reset();
        tick();
        n_checks++; if (valid_out !== 1'b0 || mem_address !== 32'd33) begin n_fail++; $display("FAIL two_word_c1 got v=%b addr=%h want v=0 addr=21", valid_out, mem_address); end
        tick();
        n_checks++;
        if (valid_out !== 1'b1 || instr_out !== 16'hD020 || imm_out !== 16'h0005 ||
            pc_out !== 32'd32 || mem_address !== 32'd34) begin
            n_fail++;
            $display("FAIL two_word_c2 got v=%b ins=%h imm=%h pc=%h addr=%h want 1 D020 0005 20 22",
                     valid_out, instr_out, imm_out, pc_out, mem_address);
        end
    endtask

    task automatic test_branch_imm();
        mem_clear();
        mem[32] = 16'hD020;
        mem[33] = 16'h0005;
        mem[64] = 16'h1111;
        do_reset();
        tick();
        branch_taken = 1'b1; branch_target = 32'h40;
        tick();
        branch_taken = 1'b0;
        #1;
        n_checks++; if (valid_out !== 1'b0 || mem_address !== 32'h40) begin n_fail++; $display("FAIL branch_redirect got v=%b addr=%h want v=0 addr=40", valid_out, mem_address); end
        tick();
        n_checks++;
        if (valid_out !== 1'b1 || pc_out !== 32'h40 || instr_out !== 16'h1111 || imm_out !== 16'h0) begin
            n_fail++;
            $display("FAIL branch_target got v=%b pc=%h ins=%h imm=%h want 1 40 1111 0", valid_out, pc_out, instr_out, imm_out);
        end
    endtask

    task automatic test_interrupt();
        mem_clear();
        mem[0]     = 16'h0100;
        mem[16'h100] = 16'h2222;
        do_reset();
        tick(); tick(); tick();
        n_checks++; if (mem_address !== 32'd35 || pc_out !== 32'd34) begin n_fail++; $display("FAIL irq_pre got addr=%h pc=%h want 23 22", mem_address, pc_out); end
        irq = 1'b1;
        tick();
        irq = 1'b0;
        #1;
        n_checks++;
        if (ret_pc_out !== 32'd35 || valid_out !== 1'b0 || mem_address !== 32'd0) begin
            n_fail++;
            $display("FAIL irq_entry got ret=%h v=%b addr=%h want 23 0 0", ret_pc_out, valid_out, mem_address);
        end
        tick();
        n_checks++; if (mem_address !== 32'h100 || valid_out !== 1'b0) begin n_fail++; $display("FAIL irq_vector got addr=%h v=%b want 100 0", mem_address, valid_out); end
        tick();
        n_checks++; if (valid_out !== 1'b1 || pc_out !== 32'h100 || instr_out !== 16'h2222) begin n_fail++; $display("FAIL irq_handler got v=%b pc=%h ins=%h want 1 100 2222", valid_out, pc_out, instr_out); end
    endtask

    task automatic test_stall_irq();
        mem_clear();
        mem[0] = 16'h0100;
        do_reset();
        tick(); tick();
        stall = 1'b1;
        #1;
        n_checks++; if (mem_read !== 1'b0 || mem_cs !== 1'b0) begin n_fail++; $display("FAIL stall_strobe got rd=%b cs=%b want 0", mem_read, mem_cs); end
        for (int k = 0; k < 3; k++) begin
            irq = (k == 1);
            tick();
            irq = 1'b0;
            #1;
            n_checks++;
            if (valid_out !== 1'b1 || pc_out !== 32'd33 || mem_address !== 32'd34 || mem_read !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold_%0d got v=%b pc=%h addr=%h rd=%b want 1 21 22 0", k, valid_out, pc_out, mem_address, mem_read);
            end
        end
        stall = 1'b0;
        tick();
        n_checks++;
        if (ret_pc_out !== 32'd34 || valid_out !== 1'b0 || mem_address !== 32'd0) begin
            n_fail++;
            $display("FAIL stall_irq_entry got ret=%h v=%b addr=%h want 22 0 0", ret_pc_out, valid_out, mem_address);
        end
    endtask

    task automatic test_reset_mid();
        mem_clear();
        mem[32] = 16'h1234;
        mem[33] = 16'hD020;
        mem[34] = 16'h0005;
        do_reset();
        tick(); tick();
        n_checks++; if (mem_address !== 32'd34 || instr_out !== 16'h1234) begin n_fail++; $display("FAIL rstmid_pre got addr=%h ins=%h want 22 1234", mem_address, instr_out); end
        rst = 1'b1;
        tick();
        n_checks++;
        if (instr_out !== 16'h0 || imm_out !== 16'h0 || pc_out !== 32'h0 || valid_out !== 1'b0 ||
            ret_pc_out !== 32'h0 || mem_address !== 32'd32) begin
            n_fail++;
            $display("FAIL rstmid_values got ins=%h imm=%h pc=%h v=%b ret=%h addr=%h want 0 0 0 0 0 20",
                     instr_out, imm_out, pc_out, valid_out, ret_pc_out, mem_address);
        end
        rst = 1'b0;
        tick();
        n_checks++; if (valid_out !== 1'b1 || pc_out !== 32'd32 || instr_out !== 16'h1234 || imm_out !== 16'h0) begin n_fail++; $display("FAIL rstmid_restart got v=%b pc=%h ins=%h imm=%h want 1 20 1234 0", valid_out, pc_out, instr_out, imm_out); end
    endtask

    task automatic test_wrap();
        mem_clear();
        mem[12'hFFF] = 16'h0777;
        do_reset();
        branch_taken = 1'b1; branch_target = 32'hFFFF_FFFF;
        tick();
        branch_taken = 1'b0;
        #1;
        n_checks++; if (mem_address !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL wrap_addr got %h want ffffffff", mem_address); end
        tick();
        n_checks++; if (mem_address !== 32'h0 || pc_out !== 32'hFFFF_FFFF || valid_out !== 1'b1) begin n_fail++; $display("FAIL wrap_next got addr=%h pc=%h v=%b want 0 ffffffff 1", mem_address, pc_out, valid_out); end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: tracks the PC to read next, whether an opcode
    // word is waiting for its immediate, whether the next read is the
    // vector word, and the interrupt latch.
    // ------------------------------------------------------------------
    logic [31:0] m_pc, m_hold_pc, e_pc, e_ret;
    logic [15:0] m_hold_w, e_instr, e_imm;
    bit          m_half, m_vec, m_pend, e_valid;

    function automatic logic [31:0] model_addr();
        return m_vec ? C_VEC_ADDR : m_pc;
    endfunction

    task automatic model_step(input bit r, input bit b, input logic [31:0] t, input bit s, input bit i);
        logic [15:0] word;
        word = mem[model_addr() & 32'hFFF];
        if (r) begin
            m_pc = C_RESET_PC; m_half = 0; m_vec = 0; m_pend = 0;
            e_instr = 0; e_imm = 0; e_pc = 0; e_valid = 0; e_ret = 0;
        end else if (b) begin
            m_pc = t; m_half = 0; m_vec = 0; e_valid = 0;
            if (i) m_pend = 1;
        end else if (s) begin
            if (i) m_pend = 1;
        end else if (m_vec) begin
            m_pc = 32'(word); m_vec = 0; e_valid = 0;
            if (i) m_pend = 1;
        end else if (m_half) begin
            e_instr = m_hold_w; e_imm = word; e_pc = m_hold_pc; e_valid = 1;
            m_pc = m_pc + 1; m_half = 0;
            if (i) m_pend = 1;
        end else if (i || m_pend) begin
            e_ret = m_pc; e_valid = 0; m_vec = 1; m_pend = 0;
        end else if (word[15:14] == 2'b11) begin
            m_hold_w = word; m_hold_pc = m_pc; m_half = 1; e_valid = 0;
            m_pc = m_pc + 1;
        end else begin
            e_instr = word; e_imm = 0; e_pc = m_pc; e_valid = 1;
            m_pc = m_pc + 1;
        end
    endtask

    task automatic test_random();
        bit r, b, s, i;
        logic [31:0] t;
        for (int a = 0; a < 4096; a++) mem[a] = 16'($urandom);
        mem[0] = 16'($urandom_range(0, 4095));
        do_reset();
        model_step(1, 0, 0, 0, 0);
        for (int c = 0; c < 3000; c++) begin
            r = ($urandom_range(0, 199) == 0);
            b = ($urandom_range(0, 99) < 6);
            s = ($urandom_range(0, 99) < 15);
            i = ($urandom_range(0, 99) < 4);
            t = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFE : 32'($urandom_range(0, 4095));
            rst = r; branch_taken = b; branch_target = t; stall = s; irq = i;
            #1;
            n_checks++;
            if (mem_address !== model_addr() || mem_read !== !(r || s) || mem_cs !== !(r || s)) begin
                n_fail++;
                $display("FAIL rand_port cyc=%0d got addr=%h rd=%b cs=%b want addr=%h rd=%b",
                         c, mem_address, mem_read, mem_cs, model_addr(), !(r || s));
            end
            @(posedge clk);
            model_step(r, b, t, s, i);
            #1;
            n_checks++;
            if (valid_out !== e_valid || ret_pc_out !== e_ret ||
                (e_valid && (instr_out !== e_instr || imm_out !== e_imm || pc_out !== e_pc))) begin
                n_fail++;
                $display("FAIL rand_out cyc=%0d got v=%b ins=%h imm=%h pc=%h ret=%h want v=%b ins=%h imm=%h pc=%h ret=%h",
                         c, valid_out, instr_out, imm_out, pc_out, ret_pc_out,
                         e_valid, e_instr, e_imm, e_pc, e_ret);
            end
        end
        rst = 0; branch_taken = 0; stall = 0; irq = 0;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_two_word();
        test_branch_imm();
        test_interrupt();
        test_stall_irq();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_fetch_unit
`default_nettype wire
